// File: rtl/rgb_pwm_pkg.sv
// ============================================================================
// rgb_pwm_pkg
// Shared FSM encoding and control-register field positions for rgb_pwm_core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } pwm_state_t;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;
  localparam int CTRL_PSC_LSB = 8;

endpackage

`default_nettype wire

// File: rtl/rgb_pwm_if.sv
// ============================================================================
// rgb_pwm_if
// Register inputs from the AXI4-Lite slave and LED-side outputs of the core.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rgb_pwm_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_DATA_WIDTH-1:0] reg0_red;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg1_green;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg2_blue;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg3_ctrl;
  logic                          pwm_r;
  logic                          pwm_g;
  logic                          pwm_b;
  logic                          period_strobe;
  logic                          busy;

  modport master (
    output reg0_red, reg1_green, reg2_blue, reg3_ctrl,
    input  pwm_r, pwm_g, pwm_b, period_strobe, busy
  );

  modport slave (
    input  reg0_red, reg1_green, reg2_blue, reg3_ctrl,
    output pwm_r, pwm_g, pwm_b, period_strobe, busy
  );
endinterface

`default_nettype wire

// File: rtl/rgb_pwm_core_channel.sv
// ============================================================================
// pwm_channel
// One colour: shadow duty register, counter compare and registered output pin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_channel #(
  parameter int PWM_WIDTH = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 load,
  input  wire logic                 active,
  input  wire logic                 inv,
  input  wire logic [PWM_WIDTH-1:0] duty_in,
  input  wire logic [PWM_WIDTH-1:0] cnt,
  output logic                      pwm
);
  logic [PWM_WIDTH-1:0] duty_sh;
  logic                 raw;

  assign raw = (cnt < duty_sh);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load) duty_sh <= duty_in;
      // Outside RUN/DRAIN the pin rests at the invert level.
      pwm <= active ? (raw ^ inv) : inv;
    end
  end
endmodule

`default_nettype wire

// File: rtl/rgb_pwm_core.sv
// ============================================================================
// rgb_pwm_core
// Three-channel PWM with shadow registers reloaded only at period boundaries.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rgb_pwm_core
  import rgb_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PWM_WIDTH          = 8,
  parameter int PRESCALE_WIDTH     = 8
) (
  input wire logic ACLK,
  input wire logic ARESETN,
  rgb_pwm_if.slave bus
);
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = {{(PWM_WIDTH-1){1'b1}}, 1'b0};

  pwm_state_t                state, state_nxt;
  logic [PRESCALE_WIDTH-1:0] psc_cnt, psc_sh;
  logic [PWM_WIDTH-1:0]      cnt;
  logic                      inv_sh;
  logic                      strobe_q;
  logic                      en, active, tick, wrap, load;
  logic                      unused_bits;

  assign en     = bus.reg3_ctrl[CTRL_EN_BIT];
  assign active = (state == ST_RUN) || (state == ST_DRAIN);
  assign tick   = active && (psc_cnt == psc_sh);
  assign wrap   = tick && (cnt == CNT_MAX);

  assign unused_bits = ^{bus.reg0_red[C_S_AXI_DATA_WIDTH-1:PWM_WIDTH],
                         bus.reg1_green[C_S_AXI_DATA_WIDTH-1:PWM_WIDTH],
                         bus.reg2_blue[C_S_AXI_DATA_WIDTH-1:PWM_WIDTH],
                         bus.reg3_ctrl[CTRL_PSC_LSB-1:CTRL_INV_BIT+1],
                         bus.reg3_ctrl[C_S_AXI_DATA_WIDTH-1:CTRL_PSC_LSB+PRESCALE_WIDTH]};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_LOAD;
      ST_LOAD: begin
        load      = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (wrap) begin
          if (en) load = 1'b1;
          else    state_nxt = ST_IDLE;
        end else if (!en) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (wrap) state_nxt = en ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= ST_IDLE;
      psc_cnt  <= '0;
      psc_sh   <= '0;
      cnt      <= '0;
      inv_sh   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      strobe_q <= load;
      // A reload restarts both counters, so the strobe lands on the first cnt==0 cycle.
      if (load) begin
        psc_sh  <= bus.reg3_ctrl[CTRL_PSC_LSB +: PRESCALE_WIDTH];
        inv_sh  <= bus.reg3_ctrl[CTRL_INV_BIT];
        psc_cnt <= '0;
        cnt     <= '0;
      end else if (active) begin
        if (tick) begin
          psc_cnt <= '0;
          cnt     <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end else begin
          psc_cnt <= psc_cnt + 1'b1;
        end
      end
    end
  end

  pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_red (
    .clk(ACLK), .rst_n(ARESETN), .load(load), .active(active), .inv(inv_sh),
    .duty_in(bus.reg0_red[PWM_WIDTH-1:0]), .cnt(cnt), .pwm(bus.pwm_r)
  );

  pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_green (
    .clk(ACLK), .rst_n(ARESETN), .load(load), .active(active), .inv(inv_sh),
    .duty_in(bus.reg1_green[PWM_WIDTH-1:0]), .cnt(cnt), .pwm(bus.pwm_g)
  );

  pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_blue (
    .clk(ACLK), .rst_n(ARESETN), .load(load), .active(active), .inv(inv_sh),
    .duty_in(bus.reg2_blue[PWM_WIDTH-1:0]), .cnt(cnt), .pwm(bus.pwm_b)
  );

  assign bus.period_strobe = strobe_q;
  assign bus.busy          = (state != ST_IDLE);
endmodule

`default_nettype wire
